// File: rtl/onchip_mem_pkg.sv
// Shared types and widths for the on-chip RAM burst adapter.
package onchip_mem_pkg;

  localparam int MEM_ADDR_W  = 15;
  localparam int MEM_DATA_W  = 32;
  localparam int MEM_BE_W    = 4;
  localparam int MEM_BURST_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_t;

endpackage

// File: rtl/onchip_burst_addr_gen.sv
// Burst address generator: base + beat index (wrapping), plus beats-remaining count.
module onchip_burst_addr_gen
  import onchip_mem_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int BURST_W = MEM_BURST_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               advance,
  input  logic [ADDR_W-1:0]  load_base,
  input  logic [BURST_W-1:0] load_remaining,
  output logic [ADDR_W-1:0]  addr,
  output logic [BURST_W-1:0] remaining
);

  logic [ADDR_W-1:0]  base;
  logic [BURST_W-1:0] idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      base      <= '0;
      idx       <= '0;
      remaining <= '0;
    end else if (load) begin
      // beat 0 is issued straight from the command, so the stored index starts at 1
      base      <= load_base;
      idx       <= BURST_W'(1);
      remaining <= load_remaining;
    end else if (advance) begin
      idx       <= idx + BURST_W'(1);
      remaining <= remaining - BURST_W'(1);
    end
  end

  assign addr = base + ADDR_W'(idx);

endmodule

// File: rtl/onchip_mem_burst_adapter.sv
// Avalon-MM burst slave converting bursts into single-word accesses to a 1-cycle on-chip RAM.
module onchip_mem_burst_adapter
  import onchip_mem_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int BE_W    = MEM_BE_W,
  parameter int BURST_W = MEM_BURST_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hold,
  input  logic [ADDR_W-1:0]  s_address,
  input  logic [BURST_W-1:0] s_burstcount,
  input  logic               s_read,
  input  logic               s_write,
  input  logic [DATA_W-1:0]  s_writedata,
  input  logic [BE_W-1:0]    s_byteenable,
  output logic               s_waitrequest,
  output logic [DATA_W-1:0]  s_readdata,
  output logic               s_readdatavalid,
  output logic [ADDR_W-1:0]  m_address,
  output logic [BE_W-1:0]    m_byteenable,
  output logic               m_chipselect,
  output logic               m_write,
  output logic [DATA_W-1:0]  m_writedata,
  output logic               m_clken,
  input  logic [DATA_W-1:0]  m_readdata
);

  state_t             state_q, state_d;
  logic               rdv_q;
  logic               load, advance, issue_rd;
  logic [BURST_W-1:0] n_beats, remaining;
  logic [ADDR_W-1:0]  ag_addr;
  logic               last_beat;

  assign n_beats   = (s_burstcount == '0) ? BURST_W'(1) : s_burstcount;
  assign last_beat = (remaining == BURST_W'(1));

  onchip_burst_addr_gen #(
    .ADDR_W  (ADDR_W),
    .BURST_W (BURST_W)
  ) u_addr_gen (
    .clk            (clk),
    .reset          (reset),
    .load           (load),
    .advance        (advance),
    .load_base      (s_address),
    .load_remaining (n_beats - BURST_W'(1)),
    .addr           (ag_addr),
    .remaining      (remaining)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!hold) begin
      unique case (state_q)
        IDLE: begin
          if (s_write && n_beats > BURST_W'(1))     state_d = WR;
          else if (s_read && !s_write && n_beats > BURST_W'(1)) state_d = RD;
        end
        WR:      if (s_write && last_beat) state_d = IDLE;
        RD:      if (last_beat)            state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    s_waitrequest = 1'b1;
    m_address     = ag_addr;
    m_byteenable  = s_byteenable;
    m_chipselect  = 1'b0;
    m_write       = 1'b0;
    m_writedata   = s_writedata;
    m_clken       = 1'b1;
    load          = 1'b0;
    advance       = 1'b0;
    issue_rd      = 1'b0;
    if (!reset) begin
      if (hold) begin
        m_clken = 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            s_waitrequest = 1'b0;
            if (s_write) begin
              m_address    = s_address;
              m_chipselect = 1'b1;
              m_write      = 1'b1;
              load         = 1'b1;
            end else if (s_read) begin
              m_address    = s_address;
              m_byteenable = '1;
              m_chipselect = 1'b1;
              load         = 1'b1;
              issue_rd     = 1'b1;
            end
          end
          WR: begin
            s_waitrequest = 1'b0;
            if (s_write) begin
              m_chipselect = 1'b1;
              m_write      = 1'b1;
              advance      = 1'b1;
            end
          end
          RD: begin
            m_byteenable = '1;
            m_chipselect = 1'b1;
            advance      = 1'b1;
            issue_rd     = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // pending valid freezes under hold; RAM q stays put because clken is low
  always_ff @(posedge clk) begin
    if (reset)      rdv_q <= 1'b0;
    else if (!hold) rdv_q <= issue_rd;
  end

  assign s_readdatavalid = rdv_q & ~hold & ~reset;
  assign s_readdata      = m_readdata;

endmodule

// File: tb/tb_onchip_mem_burst_adapter.sv
// Directed bench: RAM model behind the DUT, reference memory model and a per-cycle compare process.
module tb_onchip_mem_burst_adapter;

  logic        clk = 1'b0;
  logic        reset, hold;
  logic [14:0] s_address;
  logic [4:0]  s_burstcount;
  logic        s_read, s_write;
  logic [31:0] s_writedata;
  logic [3:0]  s_byteenable;
  logic        s_waitrequest;
  logic [31:0] s_readdata;
  logic        s_readdatavalid;
  logic [14:0] m_address;
  logic [3:0]  m_byteenable;
  logic        m_chipselect, m_write;
  logic [31:0] m_writedata;
  logic        m_clken;
  logic [31:0] m_readdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  onchip_mem_burst_adapter #(
    .ADDR_W(15), .DATA_W(32), .BE_W(4), .BURST_W(5)
  ) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .s_address(s_address), .s_burstcount(s_burstcount),
    .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid),
    .m_address(m_address), .m_byteenable(m_byteenable),
    .m_chipselect(m_chipselect), .m_write(m_write),
    .m_writedata(m_writedata), .m_clken(m_clken),
    .m_readdata(m_readdata)
  );

  // RAM model: registered address, unregistered q, everything gated by clken
  logic [31:0] ram [0:32767];
  logic [14:0] ram_areg;
  int          wr_cnt = 0;
  logic [14:0] wr_log[$];

  assign m_readdata = ram[ram_areg];

  always @(posedge clk) begin
    if (m_clken) begin
      if (m_chipselect && m_write) begin
        logic [31:0] mask;
        for (int b = 0; b < 4; b++) mask[b*8 +: 8] = {8{m_byteenable[b]}};
        ram[m_address] <= (ram[m_address] & ~mask) | (m_writedata & mask);
        wr_cnt = wr_cnt + 1;
        wr_log.push_back(m_address);
      end
      ram_areg <= m_address;
    end
  end

  // Reference model: what memory must contain and what reads must return
  logic [31:0] model_mem [0:32767];
  logic [31:0] exp_q[$];
  logic [31:0] last_rd;
  int          valid_cnt = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        check_eq("rst_wait", 32'(s_waitrequest), 32'd1);
        check_eq("rst_rdv", 32'(s_readdatavalid), 32'd0);
        check_eq("rst_clken", 32'(m_clken), 32'd1);
        check_eq("rst_cs_wr", {30'd0, m_chipselect, m_write}, 32'd0);
      end else if (hold) begin
        check_eq("hold_clken", 32'(m_clken), 32'd0);
        check_eq("hold_rdv", 32'(s_readdatavalid), 32'd0);
        check_eq("hold_wait", 32'(s_waitrequest), 32'd1);
      end
      if (s_readdatavalid) begin
        valid_cnt++;
        last_rd = s_readdata;
        check_eq("stale_valid", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check_eq("rd_data", s_readdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] wd  [0:15];
  logic [3:0]  wbe [0:15];
  logic        also_read = 1'b0;

  task automatic do_write(input logic [14:0] a, input logic [4:0] bc, input int n, input int gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps[i]) begin
        @(negedge clk);
        s_write = 1'b0; s_read = 1'b0;
        #1 check_eq("wr_gap_wait", 32'(s_waitrequest), 32'd0);
        @(posedge clk);
      end
      @(negedge clk);
      s_write = 1'b1; s_writedata = wd[i]; s_byteenable = wbe[i];
      if (i == 0) begin
        s_address = a; s_burstcount = bc; s_read = also_read;
      end else begin
        s_read = 1'b0;
      end
      #1 check_eq("wr_accept", 32'(s_waitrequest), 32'd0);
      @(posedge clk);
      begin
        logic [31:0] mask;
        logic [14:0] wa;
        wa = a + 15'(i);
        for (int b = 0; b < 4; b++) mask[b*8 +: 8] = {8{wbe[i][b]}};
        model_mem[wa] = (model_mem[wa] & ~mask) | (wd[i] & mask);
      end
    end
    @(negedge clk);
    s_write = 1'b0; s_read = 1'b0;
  endtask

  task automatic do_read(input logic [14:0] a, input logic [4:0] bc, input int n);
    @(negedge clk);
    s_address = a; s_burstcount = bc; s_read = 1'b1; s_write = 1'b0;
    #1 check_eq("rd_accept", 32'(s_waitrequest), 32'd0);
    for (int i = 0; i < n; i++) exp_q.push_back(model_mem[a + 15'(i)]);
    @(posedge clk);
    @(negedge clk);
    s_read = 1'b0;
    for (int k = 1; k <= n; k++) begin
      #1;
      check_eq("rd_valid_timing", 32'(s_readdatavalid), 32'd1);
      check_eq("rd_wait", 32'(s_waitrequest), (k < n) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    int start;
    reset = 1'b1; hold = 1'b0; s_address = '0; s_burstcount = '0;
    s_read = 1'b0; s_write = 1'b0; s_writedata = '0; s_byteenable = '0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("reset_wait", 32'(s_waitrequest), 32'd1);
    check_eq("reset_rdv", 32'(s_readdatavalid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 check_eq("idle_wait", 32'(s_waitrequest), 32'd0);

    // single write then read
    wd[0] = 32'hDEADBEEF; wbe[0] = 4'hF;
    do_write(15'h0010, 5'd1, 1, 0);
    do_read(15'h0010, 5'd1, 1);
    check_eq("single_rd_lit", last_rd, 32'hDEADBEEF);

    // 16-beat burst write and read
    for (int i = 0; i < 16; i++) begin wd[i] = 32'h100 + 32'(i); wbe[i] = 4'hF; end
    do_write(15'h0200, 5'd16, 16, 0);
    do_read(15'h0200, 5'd16, 16);
    check_eq("burst_rd_last_lit", last_rd, 32'h0000010F);

    // wrap and byteenable
    for (int i = 0; i < 3; i++) begin wd[i] = 32'hFFFFFFFF; wbe[i] = 4'hF; end
    do_write(15'h7FFF, 5'd3, 3, 0);
    wr_log.delete();
    wd[0] = 32'hCAFE0001; wbe[0] = 4'hF;
    wd[1] = 32'h00001234; wbe[1] = 4'h3;
    wd[2] = 32'hCAFE0002; wbe[2] = 4'hF;
    do_write(15'h7FFF, 5'd3, 3, 0);
    check_eq("wrap_log_n", 32'(wr_log.size()), 32'd3);
    if (wr_log.size() == 3) begin
      check_eq("wrap_addr0", 32'(wr_log[0]), 32'h7FFF);
      check_eq("wrap_addr1", 32'(wr_log[1]), 32'h0000);
      check_eq("wrap_addr2", 32'(wr_log[2]), 32'h0001);
    end
    do_read(15'h0000, 5'd1, 1);
    check_eq("wrap_be_lit", last_rd, 32'hFFFF1234);
    do_read(15'h7FFF, 5'd3, 3);

    // hold for 3 cycles after the second issue of a 4-beat read
    start = valid_cnt;
    @(negedge clk);
    s_address = 15'h0204; s_burstcount = 5'd4; s_read = 1'b1;
    #1 check_eq("hold_rd_accept", 32'(s_waitrequest), 32'd0);
    for (int i = 0; i < 4; i++) exp_q.push_back(model_mem[15'h0204 + 15'(i)]);
    @(posedge clk);
    @(negedge clk);
    s_read = 1'b0;
    @(posedge clk);
    @(negedge clk);
    hold = 1'b1;
    repeat (3) begin
      #1 check_eq("hold_no_valid", 32'(s_readdatavalid), 32'd0);
      @(negedge clk);
    end
    hold = 1'b0;
    #1 check_eq("hold_resume", 32'(s_readdatavalid), 32'd1);
    repeat (6) @(negedge clk);
    check_eq("hold_valid_cnt", 32'(valid_cnt - start), 32'd4);
    check_eq("hold_last_lit", last_rd, 32'h00000107);

    // reset in the middle of an 8-beat read
    @(negedge clk);
    s_address = 15'h0200; s_burstcount = 5'd8; s_read = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(model_mem[15'h0200 + 15'(i)]);
    @(posedge clk);
    @(negedge clk);
    s_read = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rst_mid_idle", 32'(s_waitrequest), 32'd0);
    check_eq("rst_mid_rdv", 32'(s_readdatavalid), 32'd0);
    repeat (3) @(negedge clk);
    do_read(15'h0010, 5'd1, 1);
    check_eq("post_rst_lit", last_rd, 32'hDEADBEEF);

    // gapped 4-beat write
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA000_0000 + 32'(i); wbe[i] = 4'hF; end
    start = wr_cnt;
    do_write(15'h0300, 5'd4, 4, 32'b0110);
    check_eq("gap_wr_cnt", 32'(wr_cnt - start), 32'd4);
    do_read(15'h0300, 5'd4, 4);
    check_eq("gap_last_lit", last_rd, 32'hA0000003);

    // burstcount 0 behaves as a single beat
    wr_log.delete();
    wd[0] = 32'h5A5A0000; wbe[0] = 4'hF;
    do_write(15'h0400, 5'd0, 1, 0);
    wd[0] = 32'h5A5A0001;
    do_write(15'h0410, 5'd1, 1, 0);
    check_eq("bc0_log_n", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() == 2) check_eq("bc0_addr2", 32'(wr_log[1]), 32'h0410);
    do_read(15'h0400, 5'd0, 1);
    check_eq("bc0_rd_lit", last_rd, 32'h5A5A0000);

    // simultaneous read and write in IDLE: write wins
    start = valid_cnt;
    wd[0] = 32'h0BADF00D; wbe[0] = 4'hF;
    also_read = 1'b1;
    do_write(15'h0500, 5'd1, 1, 0);
    also_read = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("simul_no_valid", 32'(valid_cnt - start), 32'd0);
    do_read(15'h0500, 5'd1, 1);
    check_eq("simul_rd_lit", last_rd, 32'h0BADF00D);

    repeat (5) @(negedge clk);
    check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
